xscaler: RTL

- Horizontal nearest-neighbour scaler on an AXI4-Stream video path. Sits directly downstream of yscaler and consumes its output.
- Converts each input line of s_width pixels into m_width pixels.
- Repeats pixels to upscale and drops pixels to downscale, using an integer DDA (error accumulator). No multipliers or dividers.

---
 rtl/xscaler_pkg.sv | 17 +
 rtl/xscaler_dda.sv | 42 ++++
 rtl/xscaler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/xscaler_pkg.sv
// Shared constants for the xscaler horizontal nearest-neighbour scaler.
package xscaler_pkg;

    // Error accumulator holds err + m_width without overflow.
    function automatic int err_width(input int reso_width);
        return reso_width + 1;
    endfunction

    // Extra bit used while comparing/subtracting the held repeat accumulator.
    localparam int HOLD_REP_GUARD_W = 1;

    // Flag positions in the packed output register {pixel, eol, sof}.
    localparam int OUT_SOF_BIT = 0;
    localparam int OUT_EOL_BIT = 1;
    localparam int OUT_FLAG_W  = 2;

endpackage

// File: rtl/xscaler_dda.sv
// DDA step: the held accumulator encodes the remaining repeats of the held
// pixel (one repeat per s_width of excess); each emitted beat subtracts once.
module xscaler_dda
    import xscaler_pkg::*;
#(
    parameter int C_RESO_WIDTH = 12
) (
    input  logic [err_width(C_RESO_WIDTH)-1:0] err_i,
    input  logic [C_RESO_WIDTH-1:0]            s_width_i,
    input  logic [C_RESO_WIDTH-1:0]            m_width_i,
    input  logic                               line_start_i,
    input  logic                               step_i,
    input  logic                               load_i,
    output logic                               rep_o,
    output logic                               last_o,
    output logic [err_width(C_RESO_WIDTH)-1:0] err_d_o
);
    localparam int EW = err_width(C_RESO_WIDTH);
    localparam int GW = EW + HOLD_REP_GUARD_W;

    logic [GW-1:0] err_x;
    logic [GW-1:0] sw_x;
    logic [GW-1:0] diff_x;
    logic [EW-1:0] base;

    assign err_x  = GW'(err_i);
    assign sw_x   = GW'(s_width_i);
    assign diff_x = err_x - sw_x;

    // Zero widths never produce a repeat, so the input is simply discarded.
    assign rep_o  = (s_width_i != '0) && (m_width_i != '0) && (err_x >= sw_x);
    assign last_o = rep_o && (diff_x < sw_x);

    always_comb begin
        base = step_i ? diff_x[EW-1:0] : err_i;
        if (load_i && line_start_i) begin
            base = '0;
        end
        err_d_o = load_i ? (base + EW'(m_width_i)) : base;
    end

endmodule

// File: rtl/xscaler.sv
// Horizontal nearest-neighbour scaler (AXI4-Stream), s_width -> m_width pixels.
// Define XSCALER_CHECK_EN to add the sticky err_eol/err_sof framing checks.
module xscaler
    import xscaler_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 16,
    parameter int C_RESO_WIDTH  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fsync,
    input  logic [C_RESO_WIDTH-1:0]  s_width,
    input  logic [C_RESO_WIDTH-1:0]  m_width,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
`ifdef XSCALER_CHECK_EN
    ,
    output logic                     err_eol,
    output logic                     err_sof
`endif
);
    localparam int EW = err_width(C_RESO_WIDTH);
    localparam int OW = C_PIXEL_WIDTH + OUT_FLAG_W;
    localparam logic [C_RESO_WIDTH-1:0] ONE = C_RESO_WIDTH'(1);

    logic [C_RESO_WIDTH-1:0]  s_width_q, m_width_q;
    logic [C_RESO_WIDTH-1:0]  in_col_q, in_col_d, col_cur;
    logic [C_RESO_WIDTH-1:0]  out_col_q, out_col_d;
    logic [EW-1:0]            err_q, err_d;
    logic [C_PIXEL_WIDTH-1:0] pix_q;
    logic                     sof_q, sof_d;
    logic [OW-1:0]            out_q, out_d;
    logic                     out_valid_q;
    logic                     degen, rep, last, load_en, move, accept, line_start, eol;

    assign degen      = (s_width_q == '0) || (m_width_q == '0);
    assign load_en    = !out_valid_q || m_axis_tready;
    assign move       = rep && load_en && !fsync;
    assign s_axis_tready = !reset && (degen || !rep || (load_en && last));
    assign accept     = s_axis_tvalid && s_axis_tready && !fsync && !degen;
    // An input SOF restarts the line wherever the column counters happen to be.
    assign line_start = s_axis_tuser || (in_col_q == '0);
    assign col_cur    = s_axis_tuser ? '0 : in_col_q;
    assign in_col_d   = (col_cur == s_width_q - ONE) ? '0 : col_cur + ONE;
    assign eol        = (out_col_q == m_width_q - ONE);

    xscaler_dda #(
        .C_RESO_WIDTH (C_RESO_WIDTH)
    ) u_dda (
        .err_i        (err_q),
        .s_width_i    (s_width_q),
        .m_width_i    (m_width_q),
        .line_start_i (line_start),
        .step_i       (move),
        .load_i       (accept),
        .rep_o        (rep),
        .last_o       (last),
        .err_d_o      (err_d)
    );

    always_comb begin
        out_col_d = out_col_q;
        if (accept && s_axis_tuser) begin
            out_col_d = '0;
        end else if (move) begin
            out_col_d = eol ? '0 : out_col_q + ONE;
        end
        // A pending SOF rides on the next emitted beat, even across k=0 pixels.
        sof_d = sof_q;
        if (move) begin
            sof_d = 1'b0;
        end
        if (accept && s_axis_tuser) begin
            sof_d = 1'b1;
        end
        out_d                         = '0;
        out_d[OW-1:OUT_FLAG_W]        = pix_q;
        out_d[OUT_EOL_BIT]            = eol;
        out_d[OUT_SOF_BIT]            = sof_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_width_q   <= s_width;
            m_width_q   <= m_width;
            err_q       <= '0;
            in_col_q    <= '0;
            out_col_q   <= '0;
            sof_q       <= 1'b0;
            pix_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fsync) begin
                s_width_q <= s_width;
                m_width_q <= m_width;
                err_q     <= '0;
                in_col_q  <= '0;
                out_col_q <= '0;
                sof_q     <= 1'b0;
            end else begin
                err_q     <= err_d;
                out_col_q <= out_col_d;
                sof_q     <= sof_d;
                if (accept) begin
                    in_col_q <= in_col_d;
                    pix_q    <= s_axis_tdata;
                end
            end
            // The output register is left alone by fsync so its beat completes.
            if (move) begin
                out_q       <= out_d;
                out_valid_q <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_q[OW-1:OUT_FLAG_W];
    assign m_axis_tuser  = out_q[OUT_SOF_BIT];
    assign m_axis_tlast  = out_q[OUT_EOL_BIT];
    assign m_axis_tvalid = out_valid_q;

`ifdef XSCALER_CHECK_EN
    logic err_eol_q, err_sof_q;

    always_ff @(posedge clk) begin
        if (reset || fsync) begin
            err_eol_q <= 1'b0;
            err_sof_q <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast != (col_cur == s_width_q - ONE)) begin
                err_eol_q <= 1'b1;
            end
            if (s_axis_tuser && (in_col_q != '0)) begin
                err_sof_q <= 1'b1;
            end
        end
    end

    assign err_eol = err_eol_q;
    assign err_sof = err_sof_q;
`endif

endmodule
